rr_mux_4to1: RTL and testbench
==============================

# rr_mux_4to1

Four-input, one-output round-robin multiplexer with valid/ready handshakes and a registered output stage. It is the combining end of the four-way demux: four independent producer channels merge onto one stream. Each output beat carries the 2-bit index of its source channel, so a downstream demux can route it back out. Arbitration is fair round-robin, and throughput is one beat per cycle.

## Interface
- WIDTH, default 8: data width of each channel.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  per-channel valid; bit k belongs to channel k.
- in_data  input  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  output  4  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  data of the held beat.
- out_sel  output  2  source channel index of the held beat.
- out_ready  input  1  downstream accept.
- in_last  input  4  end-of-packet flag per channel; present only with RR_MUX_LAST_EN.
- out_last  output  1  end-of-packet flag of the held beat; present only with RR_MUX_LAST_EN.

## Operation
- **Transfer rule.** A transfer occurs on a channel when its valid and ready are both high at a rising edge.
- **Slot free.** The slot is free when `free = !out_valid || out_ready`.
- **Grant.** When the slot is free, the arbiter grants the first channel with in_valid high. The search starts at the pointer `ptr` and proceeds `ptr, ptr+1, …` modulo 4.
  - in_ready of the granted channel equals `free`.
  - All other in_ready bits are 0.
- **Capture.** When channel k transfers, the output register loads in_data[k], out_sel takes k, out_valid goes to 1, and ptr becomes (k+1) mod 4.
- **Output accept, no new beat.** If the downstream accepts and no input transfers in the same cycle, out_valid goes to 0. out_data and out_sel hold their last values.
- **Stall.** If out_valid=1 and out_ready=0, all in_ready are 0. out_data, out_sel and ptr are held.
- **No valid inputs.** If no in_valid is high, ptr is unchanged and no grant is made.
- **Input ordering.** A channel may drop valid without a transfer. The spec places no requirement on inputs holding their values.
- **ptr width.** ptr is 2 bits and wraps naturally from 3 to 0.
- **Arbiter FSM.**
  - Without the macro, the FSM has a single state, ARB.
  - With the macro, it has two states, ARB and LOCK (see Configuration).

## Timing
- **Latency.** Input transfer at edge N puts the beat on out_* immediately after edge N: one cycle of latency.
- **Throughput.** Sustained one beat per cycle while out_ready=1.
- **Simultaneous accept and refill.** An output accept and an input transfer on the same edge replace the register contents with no bubble.
- **in_ready path.** in_ready is combinational from in_valid, ptr, out_valid and out_ready. It is 0 while rst=1.
- **Reset values.** out_valid=0, out_data=0, out_sel=0, ptr=0, state=ARB, and out_last=0 when present.
- **Reset mid-operation.** Reset discards the held beat and any lock. The next edge after rst deasserts starts arbitration at channel 0.

## Configuration
- Macro: RR_MUX_LAST_EN.
- **Defined:**
  - The in_last and out_last ports exist.
  - out_last is captured with the data.
  - A transfer from channel k with in_last[k]=0 moves ARB to LOCK on channel k. While in LOCK, only channel k can be granted, regardless of ptr.
  - A transfer from channel k with in_last[k]=1 returns the FSM to ARB.
  - ptr updates on every transfer, as in the base behaviour.
  - A one-beat packet (in_last=1 on its first beat) never enters LOCK.
- **Undefined:** every beat is arbitrated independently and no last ports exist.

## Structure
- Shared package holds:
  - the channel count constant, NCH=4;
  - the select width constant, SELW=2;
  - the arbiter state enum {ARB, LOCK}.
- Sub-module rr_arb4: combinational round-robin priority picker.
  - Inputs: 4-bit request and 2-bit ptr.
  - Outputs: one-hot grant and 2-bit index.
- The top level holds ptr, the output register, and the FSM.

## Test plan
- **Reset.** Hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0 and out_valid=0. At the first edge after release, channel 0 is granted: out_sel=0, out_data=in_data[0].
- **Rotation.** in_valid=4'b1111 with channel data 8'hA0..8'hA3 and out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, with no bubble.
- **Sparse requests.** in_valid=4'b1010 with ptr=0 -> grants alternate 1,3,1,3. Then drop to 4'b0000 -> out_valid falls one cycle after the last output accept.
- **Backpressure.** Set out_ready=0 while out_valid=1 -> in_ready=4'b0000 and out_data stays stable for 5 cycles. On releasing out_ready, the next beat lands in the same cycle the held beat is accepted.
- **Packet lock (RR_MUX_LAST_EN).** Channel 2 sends a 3-beat packet (last on beat 3) while channels 0 and 3 are valid -> out_sel=2,2,2, then 3, then 0. out_last=1 only on the third beat.
- **Reset mid-packet (RR_MUX_LAST_EN).** Assert rst after beat 1 of the channel-2 packet -> after release, state=ARB and channel 0 is granted first.

Source files
------------

// File: rtl/rr_mux_4to1_pkg.sv
// Shared constants and arbiter state type for the four-way round-robin merge.
package rr_mux_4to1_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;

endpackage

// File: rtl/rr_arb4.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NCH.
module rr_arb4
  import rr_mux_4to1_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] idx
);

  logic            found;
  logic [SELW-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      k = ptr + SELW'(i);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/rr_mux_4to1.sv
// Four-input round-robin merge with registered output and source index.
// Define RR_MUX_LAST_EN to add in_last/out_last and packet locking.
module rr_mux_4to1
  import rr_mux_4to1_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
`ifdef RR_MUX_LAST_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  arb_state_t      state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] lock_ch;
  logic            free;
  logic            xfer;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  gnt;
  logic [SELW-1:0] gnt_idx;
  logic [WIDTH-1:0] ch_data [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_split
    assign ch_data[c] = in_data[c*WIDTH +: WIDTH];
  end

  assign free = !out_valid || out_ready;

  // While locked, only the owning channel may request; ptr is ignored for
  // the search result since at most one bit survives the mask.
  always_comb begin
    req = in_valid;
    if (state == LOCK) req = in_valid & (NCH'(1) << lock_ch);
  end

  rr_arb4 u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign in_ready = (rst || !free) ? '0 : gnt;
  assign xfer     = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
      lock_ch   <= '0;
      state     <= ARB;
`ifdef RR_MUX_LAST_EN
      out_last  <= 1'b0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt_idx];
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx + 1'b1;
      lock_ch   <= gnt_idx;
`ifdef RR_MUX_LAST_EN
      out_last  <= in_last[gnt_idx];
      state     <= in_last[gnt_idx] ? ARB : LOCK;
`else
      state     <= ARB;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_4to1.sv
// Table-driven bench for rr_mux_4to1 with a beat scoreboard queue.
module tb_rr_mux_4to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef RR_MUX_LAST_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  always #5 clk = ~clk;

  rr_mux_4to1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic       ordy;
    logic [7:0] base;
    logic [3:0] last;
    logic [3:0] exp_rdy;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  logic  mvalid = 1'b0;

  function automatic vec_t mk(logic r, logic [3:0] v, logic ordy, logic [7:0] base,
                              logic [3:0] last, logic [3:0] exp_rdy);
    vec_t x;
    x.r = r; x.v = v; x.ordy = ordy; x.base = base; x.last = last; x.exp_rdy = exp_rdy;
    return x;
  endfunction

  function automatic logic [1:0] oh2idx(logic [3:0] oh);
    logic [1:0] n = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) n = 2'(i);
    return n;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic step(vec_t x);
    beat_t b;
    rst       = x.r;
    in_valid  = x.v;
    out_ready = x.ordy;
    for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = x.base + 8'(k);
`ifdef RR_MUX_LAST_EN
    in_last = x.last;
`endif
    #3;
    check("in_ready", 32'(in_ready), 32'(x.exp_rdy));
    if (mvalid && x.ordy && !x.r && sb.size() > 0) void'(sb.pop_front());
    if (x.exp_rdy != 4'b0000) begin
      b.sel  = oh2idx(x.exp_rdy);
      b.data = x.base + 8'(b.sel);
      b.last = x.last[b.sel];
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    if (x.r) begin
      mvalid = 1'b0;
      sb.delete();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sel", 32'(out_sel), 32'd0);
`ifdef RR_MUX_LAST_EN
      check("rst_out_last", 32'(out_last), 32'd0);
`endif
    end else begin
      mvalid = (x.exp_rdy != 4'b0000) || (mvalid && !x.ordy);
      check("out_valid", 32'(out_valid), 32'(mvalid));
      if (mvalid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: got empty queue want held beat (t=%0t)", $time);
        end else begin
          check("out_sel", 32'(out_sel), 32'(sb[0].sel));
          check("out_data", 32'(out_data), 32'(sb[0].data));
`ifdef RR_MUX_LAST_EN
          check("out_last", 32'(out_last), 32'(sb[0].last));
`endif
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
`ifdef RR_MUX_LAST_EN
    in_last = '0;
`endif
    // reset with every channel requesting
    vecs.push_back(mk(1, 4'b1111, 1, 8'hA0, 4'hF, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 1, 8'hA0, 4'hF, 4'b0000));
    // rotation 0,1,2,3,0 with wrap of ptr
    vecs.push_back(mk(0, 4'b1111, 1, 8'hA0, 4'hF, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 1, 8'hA0, 4'hF, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 1, 8'hA0, 4'hF, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 1, 8'hA0, 4'hF, 4'b1000));
    vecs.push_back(mk(0, 4'b1111, 1, 8'hA0, 4'hF, 4'b0001));
    // sparse 1,3,1,3 then idle
    vecs.push_back(mk(0, 4'b1010, 1, 8'h10, 4'hF, 4'b0010));
    vecs.push_back(mk(0, 4'b1010, 1, 8'h20, 4'hF, 4'b1000));
    vecs.push_back(mk(0, 4'b1010, 1, 8'h30, 4'hF, 4'b0010));
    vecs.push_back(mk(0, 4'b1010, 1, 8'h40, 4'hF, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 1, 8'h50, 4'hF, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 1, 8'h50, 4'hF, 4'b0000));
    // backpressure: one capture, five stalled cycles, then accept+refill
    vecs.push_back(mk(0, 4'b0101, 0, 8'hB0, 4'hF, 4'b0001));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 4'b0101, 0, 8'hC0 + 8'(i * 16), 4'hF, 4'b0000));
    vecs.push_back(mk(0, 4'b0101, 1, 8'hD0, 4'hF, 4'b0100));
    vecs.push_back(mk(0, 4'b0101, 1, 8'hE0, 4'hF, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 1, 8'hE0, 4'hF, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 8'hE0, 4'hF, 4'b0000));
    // mid-operation reset with ptr away from 0; channel 0 wins afterwards
    vecs.push_back(mk(0, 4'b0100, 1, 8'h60, 4'hF, 4'b0100));
    vecs.push_back(mk(1, 4'b1111, 0, 8'h70, 4'hF, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 8'h80, 4'hF, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 1, 8'h90, 4'hF, 4'b0010));
`ifdef RR_MUX_LAST_EN
    // 3-beat packet on channel 2 holds the lock against 0 and 3
    vecs.push_back(mk(0, 4'b0000, 1, 8'h00, 4'hF, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 1, 8'h10, 4'b0000, 4'b0100));
    vecs.push_back(mk(0, 4'b1101, 1, 8'h20, 4'b0000, 4'b0100));
    vecs.push_back(mk(0, 4'b1101, 1, 8'h30, 4'b0100, 4'b0100));
    vecs.push_back(mk(0, 4'b1001, 1, 8'h40, 4'hF, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 1, 8'h50, 4'hF, 4'b0001));
    // one-beat packet never locks
    vecs.push_back(mk(0, 4'b0010, 1, 8'h60, 4'b0010, 4'b0010));
    vecs.push_back(mk(0, 4'b0101, 1, 8'h70, 4'hF, 4'b0100));
    // reset in the middle of a locked packet
    vecs.push_back(mk(0, 4'b0100, 1, 8'h80, 4'b0000, 4'b0100));
    vecs.push_back(mk(1, 4'b1111, 1, 8'h90, 4'b0000, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 8'hA0, 4'b1111, 4'b0001));
    vecs.push_back(mk(0, 4'b0100, 1, 8'hB0, 4'b1111, 4'b0100));
`endif
    foreach (vecs[i]) step(vecs[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
